wos_window_scanner: RTL

- Parametrised successor of the masked 2D filter's window address generator.
- Walks every output pixel of an h×w frame for each of CHANNELS planes and emits one read address per enabled kernel tap of an n×n window.
- Masked-out taps are skipped. Border taps are either clamped or flagged as zero-padding.
- Feeds the weighted-order-statistics sorter through a valid/ready stream.

---
 rtl/wos_window_scanner.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wos_window_scanner.sv
// Window address generator for the weighted-order-statistics sorter: walks every
// pixel of every plane and streams one read address per enabled kernel tap.
module wos_window_scanner #(
   parameter int WORD        = 32,
   parameter int MAX_N       = 25,
   parameter int CHANNELS    = 1,
   parameter int KERNEL_SIZE = MAX_N * MAX_N,
   parameter int N_BITS      = $clog2(MAX_N) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WORD-1:0]        h,
   input  logic [WORD-1:0]        w,
   input  logic [N_BITS-1:0]      n,
   input  logic [KERNEL_SIZE-1:0] mask,
   input  logic                   border_mode,
   input  logic [WORD-1:0]        base_addr,
   output logic                   addr_valid,
   input  logic                   addr_ready,
   output logic [WORD-1:0]        addr,
   output logic                   pad,
   output logic                   win_last,
   output logic                   frame_last,
   output logic [WORD-1:0]        xc,
   output logic [WORD-1:0]        yc,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err
);

   localparam int KB = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW = WORD + 2;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [WORD-1:0]        h_q, h_d, w_q, w_d, base_q, base_d, plane_q, plane_d;
   logic [N_BITS-1:0]      n_q, n_d, r_q, r_d;
   logic [KERNEL_SIZE-1:0] mask_q, mask_d;
   logic                   border_q, border_d;
   logic [KB-1:0]          last_k_q, last_k_d, k_q, k_d;
   logic [CB-1:0]          c_q, c_d;
   logic [WORD-1:0]        chan_off_q, chan_off_d;
   logic [WORD-1:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [N_BITS-1:0]      kx_q, kx_d, ky_q, ky_d;
   logic                   gen_q, gen_d;
   logic                   addr_valid_q, addr_valid_d;
   logic [WORD-1:0]        addr_q, addr_d, xc_q, xc_d, yc_q, yc_d;
   logic                   pad_q, pad_d, win_last_q, win_last_d;
   logic                   frame_last_q, frame_last_d;
   logic                   busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

   // Start-time decode: which taps are live for the requested n, and the last one.
   logic [31:0]            nn_in;
   logic [KERNEL_SIZE-1:0] tap_en;
   logic [KB-1:0]          last_k_in;
   logic                   cfg_ok;

   assign nn_in = 32'(n) * 32'(n);

   generate
      for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_tap
         assign tap_en[gi] = mask[KERNEL_SIZE-1-gi] && (gi < nn_in);
      end
   endgenerate

   always_comb begin
      last_k_in = '0;
      for (int k = 0; k < KERNEL_SIZE; k++) begin
         if (tap_en[k]) begin
            last_k_in = KB'(k);
         end
      end
   end

   assign cfg_ok = (h != '0) && (w != '0) && n[0] && (n <= N_BITS'(MAX_N)) && (|tap_en);

   // Current tap geometry; coordinates carry two extra bits so they can go negative.
   logic [N_BITS-1:0] n_last;
   logic [KB-1:0]     tap_idx;
   logic              tap_on;
   logic [SW-1:0]     sy, sx;
   logic              y_low, y_high, x_low, x_high;
   logic [WORD-1:0]   y_use, x_use, row_off, pix_addr, tap_addr;
   logic              tap_pad, tap_win_last, tap_frame_last;

   always_comb begin
      n_last   = n_q - N_BITS'(1);
      tap_idx  = KB'(KERNEL_SIZE - 1) - k_q;
      tap_on   = mask_q[tap_idx];
      sy       = {2'b00, pix_y_q} + SW'(ky_q) - SW'(r_q);
      sx       = {2'b00, pix_x_q} + SW'(kx_q) - SW'(r_q);
      y_low    = sy[SW-1];
      x_low    = sx[SW-1];
      y_high   = !y_low && (sy >= {2'b00, h_q});
      x_high   = !x_low && (sx >= {2'b00, w_q});
      y_use    = y_low ? '0 : (y_high ? h_q - WORD'(1) : sy[WORD-1:0]);
      x_use    = x_low ? '0 : (x_high ? w_q - WORD'(1) : sx[WORD-1:0]);
      row_off  = y_use * w_q;
      pix_addr = base_q + chan_off_q + row_off + x_use;
      if (border_q && (y_low || y_high || x_low || x_high)) begin
         tap_pad  = 1'b1;
         tap_addr = '0;
      end else begin
         tap_pad  = 1'b0;
         tap_addr = pix_addr;
      end
      tap_win_last   = (k_q == last_k_q);
      tap_frame_last = tap_win_last && (pix_x_q == w_q - WORD'(1)) &&
                       (pix_y_q == h_q - WORD'(1)) && (c_q == CB'(CHANNELS - 1));
   end

   logic fire;
   assign fire = addr_valid_q && addr_ready;

   always_comb begin
      state_d      = state_q;
      h_d          = h_q;
      w_d          = w_q;
      base_d       = base_q;
      plane_d      = plane_q;
      n_d          = n_q;
      r_d          = r_q;
      mask_d       = mask_q;
      border_d     = border_q;
      last_k_d     = last_k_q;
      k_d          = k_q;
      c_d          = c_q;
      chan_off_d   = chan_off_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      kx_d         = kx_q;
      ky_d         = ky_q;
      gen_d        = gen_q;
      addr_valid_d = addr_valid_q;
      addr_d       = addr_q;
      pad_d        = pad_q;
      win_last_d   = win_last_q;
      frame_last_d = frame_last_q;
      xc_d         = xc_q;
      yc_d         = yc_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      cfg_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (!cfg_ok) begin
                  cfg_err_d = 1'b1;
               end else begin
                  h_d        = h;
                  w_d        = w;
                  n_d        = n;
                  mask_d     = mask;
                  border_d   = border_mode;
                  base_d     = base_addr;
                  plane_d    = h * w;
                  r_d        = (n - N_BITS'(1)) >> 1;
                  last_k_d   = last_k_in;
                  k_d        = '0;
                  c_d        = '0;
                  chan_off_d = '0;
                  pix_x_d    = '0;
                  pix_y_d    = '0;
                  kx_d       = '0;
                  ky_d       = '0;
                  gen_d      = 1'b1;
                  busy_d     = 1'b1;
                  state_d    = SCAN;
               end
            end
         end

         SCAN: begin
            if (fire) begin
               addr_valid_d = 1'b0;
               if (frame_last_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            // The output slot refills in the same cycle it drains, so a full mask streams at 1/cycle.
            if (gen_q && (!addr_valid_q || fire)) begin
               if (tap_on) begin
                  addr_valid_d = 1'b1;
                  addr_d       = tap_addr;
                  pad_d        = tap_pad;
                  win_last_d   = tap_win_last;
                  frame_last_d = tap_frame_last;
                  xc_d         = pix_x_q;
                  yc_d         = pix_y_q;
               end
               if (tap_on && tap_frame_last) begin
                  gen_d = 1'b0;
               end else if (kx_q != n_last) begin
                  kx_d = kx_q + N_BITS'(1);
                  k_d  = k_q + KB'(1);
               end else if (ky_q != n_last) begin
                  kx_d = '0;
                  ky_d = ky_q + N_BITS'(1);
                  k_d  = k_q + KB'(1);
               end else begin
                  kx_d = '0;
                  ky_d = '0;
                  k_d  = '0;
                  if (pix_x_q != w_q - WORD'(1)) begin
                     pix_x_d = pix_x_q + WORD'(1);
                  end else begin
                     pix_x_d = '0;
                     if (pix_y_q != h_q - WORD'(1)) begin
                        pix_y_d = pix_y_q + WORD'(1);
                     end else begin
                        pix_y_d    = '0;
                        c_d        = c_q + CB'(1);
                        chan_off_d = chan_off_q + plane_q;
                     end
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         h_q          <= '0;
         w_q          <= '0;
         base_q       <= '0;
         plane_q      <= '0;
         n_q          <= '0;
         r_q          <= '0;
         mask_q       <= '0;
         border_q     <= 1'b0;
         last_k_q     <= '0;
         k_q          <= '0;
         c_q          <= '0;
         chan_off_q   <= '0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         kx_q         <= '0;
         ky_q         <= '0;
         gen_q        <= 1'b0;
         addr_valid_q <= 1'b0;
         addr_q       <= '0;
         pad_q        <= 1'b0;
         win_last_q   <= 1'b0;
         frame_last_q <= 1'b0;
         xc_q         <= '0;
         yc_q         <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         w_q          <= w_d;
         base_q       <= base_d;
         plane_q      <= plane_d;
         n_q          <= n_d;
         r_q          <= r_d;
         mask_q       <= mask_d;
         border_q     <= border_d;
         last_k_q     <= last_k_d;
         k_q          <= k_d;
         c_q          <= c_d;
         chan_off_q   <= chan_off_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         kx_q         <= kx_d;
         ky_q         <= ky_d;
         gen_q        <= gen_d;
         addr_valid_q <= addr_valid_d;
         addr_q       <= addr_d;
         pad_q        <= pad_d;
         win_last_q   <= win_last_d;
         frame_last_q <= frame_last_d;
         xc_q         <= xc_d;
         yc_q         <= yc_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign addr_valid = addr_valid_q;
   assign addr       = addr_q;
   assign pad        = pad_q;
   assign win_last   = win_last_q;
   assign frame_last = frame_last_q;
   assign xc         = xc_q;
   assign yc         = yc_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;

endmodule
